lfsr_gen: RTL and testbench

Parametrised linear-feedback shift register generator: configurable width, tap polynomial, Galois/Fibonacci structure and steps per clock. It adds runtime seed load, enable gating, all-zero lock-up protection and sequence-wrap/period measurement. It serves as the pseudo-random source for scramblers, BIST pattern generators and test stimulus in the design.

---
 rtl/lfsr_gen.sv | 99 +++++++++
 tb/tb_lfsr_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator. Supports Galois or Fibonacci feedback, several steps per clock,
// seed load with all-zero protection, and wrap/period tracking against a reference state.

module lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter bit               MODE  = 1'b0
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (MODE == 1'b0) begin : g_galois
            always_comb begin
                q    = '0;
                q[0] = d[WIDTH-1];
                for (int i = 1; i < WIDTH; i++)
                    q[i] = d[i-1] ^ (TAPS[i-1] & d[WIDTH-1]);
            end
        end else begin : g_fib
            assign q = {d[WIDTH-2:0], ^(d & TAPS)};
        end
    endgenerate
endmodule

module lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter bit               MODE  = 1'b0,
    parameter int               STEPS = 1,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period
);
    logic [STEPS:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]          ref_q;
    logic [WIDTH-1:0]          cnt;
    logic [WIDTH-1:0]          cnt_nxt;
    logic [WIDTH-1:0]          nxt;

    // Unrolled step chain: chain[k] is the state after k steps from q.
    assign chain[0] = q;
    generate
        for (genvar g = 0; g < STEPS; g++) begin : g_step
            lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_step (
                .d(chain[g]),
                .q(chain[g+1])
            );
        end
    endgenerate

    assign nxt     = chain[STEPS];
    assign cnt_nxt = cnt + WIDTH'(STEPS);
    assign bit_out = q[WIDTH-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q      <= SEED;
            ref_q  <= SEED;
            cnt    <= '0;
            period <= '0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                // A zero seed would lock the register up forever; fall back to SEED.
                if (seed_in == '0) begin
                    q      <= SEED;
                    ref_q  <= SEED;
                    lockup <= 1'b1;
                end else begin
                    q     <= seed_in;
                    ref_q <= seed_in;
                end
                cnt <= '0;
            end else if (en) begin
                q <= nxt;
                if (nxt == ref_q) begin
                    wrap   <= 1'b1;
                    period <= cnt_nxt;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: three 4-bit variants (Galois, Fibonacci, two-step) and the
// 16-bit default, each driven independently and checked against a behavioural model.

module tb_lfsr_gen;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  en_v = '0;
    logic [3:0]  load_v = '0;
    logic [15:0] seed_v [4];

    logic [3:0]  q_g, q_f, q_s, per_g, per_f, per_s;
    logic [15:0] q_d, per_d;
    logic        bo_g, bo_f, bo_s, bo_d;
    logic        wr_g, wr_f, wr_s, wr_d;
    logic        lk_g, lk_f, lk_s, lk_d;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .MODE(1'b0), .STEPS(1), .SEED(4'h1)) u_g (
        .clk(clk), .rstn(rstn), .en(en_v[0]), .load(load_v[0]), .seed_in(seed_v[0][3:0]),
        .q(q_g), .bit_out(bo_g), .wrap(wr_g), .lockup(lk_g), .period(per_g));
    lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .MODE(1'b1), .STEPS(1), .SEED(4'h1)) u_f (
        .clk(clk), .rstn(rstn), .en(en_v[1]), .load(load_v[1]), .seed_in(seed_v[1][3:0]),
        .q(q_f), .bit_out(bo_f), .wrap(wr_f), .lockup(lk_f), .period(per_f));
    lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .MODE(1'b0), .STEPS(2), .SEED(4'h1)) u_s (
        .clk(clk), .rstn(rstn), .en(en_v[2]), .load(load_v[2]), .seed_in(seed_v[2][3:0]),
        .q(q_s), .bit_out(bo_s), .wrap(wr_s), .lockup(lk_s), .period(per_s));
    lfsr_gen u_d (
        .clk(clk), .rstn(rstn), .en(en_v[3]), .load(load_v[3]), .seed_in(seed_v[3]),
        .q(q_d), .bit_out(bo_d), .wrap(wr_d), .lockup(lk_d), .period(per_d));

    typedef struct {
        int          sel;
        logic [15:0] q;
        logic        wrap;
        logic        lockup;
        logic [15:0] period;
    } exp_t;
    exp_t sbq[$];

    int nchk = 0;
    int nerr = 0;

    int          mw    [4] = '{4, 4, 4, 16};
    logic [15:0] mtaps [4] = '{16'h9, 16'h9, 16'h9, 16'hB400};
    bit          mmode [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          msteps[4] = '{1, 1, 2, 1};
    logic [15:0] mq[4], mref[4], mcnt[4], mper[4];
    logic        mwrap[4], mlock[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mask(input int s);
        return 16'((32'h1 << mw[s]) - 1);
    endfunction

    function automatic logic [15:0] stp(input logic [15:0] d, input int s);
        logic [15:0] n;
        logic        fb;
        int          w = mw[s];
        n = '0;
        if (!mmode[s]) begin
            fb   = d[w-1];
            n[0] = fb;
            for (int i = 1; i < w; i++) n[i] = d[i-1] ^ (mtaps[s][i-1] & fb);
        end else begin
            fb = ^(d & mtaps[s]);
            n  = ((d << 1) | {15'b0, fb}) & mask(s);
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mq[s] = 16'h1; mref[s] = 16'h1; mcnt[s] = '0; mper[s] = '0;
            mwrap[s] = 1'b0; mlock[s] = 1'b0;
        end
    endtask

    task automatic model_step(input int s, input logic e, input logic l, input logic [15:0] sd);
        logic [15:0] n, c;
        mwrap[s] = 1'b0;
        mlock[s] = 1'b0;
        if (l) begin
            if ((sd & mask(s)) == '0) begin
                mq[s] = 16'h1; mlock[s] = 1'b1;
            end else mq[s] = sd & mask(s);
            mref[s] = mq[s];
            mcnt[s] = '0;
        end else if (e) begin
            n = mq[s];
            for (int k = 0; k < msteps[s]; k++) n = stp(n, s);
            c = (mcnt[s] + 16'(msteps[s])) & mask(s);
            mq[s] = n;
            if (n == mref[s]) begin
                mwrap[s] = 1'b1; mper[s] = c; mcnt[s] = '0;
            end else mcnt[s] = c;
        end
    endtask

    function automatic logic [15:0] get_q(input int s);
        case (s)
            0: return {12'b0, q_g};
            1: return {12'b0, q_f};
            2: return {12'b0, q_s};
            default: return q_d;
        endcase
    endfunction
    function automatic logic [15:0] get_per(input int s);
        case (s)
            0: return {12'b0, per_g};
            1: return {12'b0, per_f};
            2: return {12'b0, per_s};
            default: return per_d;
        endcase
    endfunction
    function automatic logic get_wr(input int s);
        case (s) 0: return wr_g; 1: return wr_f; 2: return wr_s; default: return wr_d; endcase
    endfunction
    function automatic logic get_lk(input int s);
        case (s) 0: return lk_g; 1: return lk_f; 2: return lk_s; default: return lk_d; endcase
    endfunction
    function automatic logic get_bo(input int s);
        case (s) 0: return bo_g; 1: return bo_f; 2: return bo_s; default: return bo_d; endcase
    endfunction

    task automatic apply(input int s, input logic e, input logic l, input logic [15:0] sd,
                         input bit cmp);
        exp_t x;
        en_v      = '0;
        load_v    = '0;
        en_v[s]   = e;
        load_v[s] = l;
        seed_v[s] = sd;
        model_step(s, e, l, sd);
        x = '{sel: s, q: mq[s], wrap: mwrap[s], lockup: mlock[s], period: mper[s]};
        sbq.push_back(x);
        @(posedge clk);
        #1;
        en_v   = '0;
        load_v = '0;
        x = sbq.pop_front();
        if (cmp) begin
            chk($sformatf("q[%0d]", x.sel), 32'(get_q(x.sel)), 32'(x.q));
            chk($sformatf("wrap[%0d]", x.sel), 32'(get_wr(x.sel)), 32'(x.wrap));
            chk($sformatf("lockup[%0d]", x.sel), 32'(get_lk(x.sel)), 32'(x.lockup));
            chk($sformatf("period[%0d]", x.sel), 32'(get_per(x.sel)), 32'(x.period));
            chk($sformatf("bit_out[%0d]", x.sel), 32'(get_bo(x.sel)),
                32'(x.q[mw[x.sel]-1]));
        end
    endtask

    logic [3:0] gtab [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                              4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    logic [3:0] ftab [5]  = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD};
    logic [3:0] stab [3]  = '{4'h4, 4'h3, 4'hC};

    initial begin
        int wcnt;
        logic wlast;
        for (int s = 0; s < 4; s++) seed_v[s] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst_q[%0d]", s), 32'(get_q(s)), 32'h1);
            chk($sformatf("rst_per[%0d]", s), 32'(get_per(s)), 32'h0);
            chk($sformatf("rst_wrap[%0d]", s), 32'(get_wr(s)), 32'h0);
            chk($sformatf("rst_lock[%0d]", s), 32'(get_lk(s)), 32'h0);
            chk($sformatf("rst_bo[%0d]", s), 32'(get_bo(s)), 32'h0);
        end

        for (int i = 0; i < 15; i++) begin
            apply(0, 1'b1, 1'b0, '0, 1'b1);
            chk($sformatf("gal_tbl%0d", i), 32'(q_g), 32'(gtab[i]));
            chk($sformatf("gal_wrap%0d", i), 32'(wr_g), (i == 14) ? 32'h1 : 32'h0);
        end
        chk("gal_period", 32'(per_g), 32'd15);

        for (int i = 0; i < 15; i++) begin
            apply(1, 1'b1, 1'b0, '0, 1'b1);
            if (i < 5) chk($sformatf("fib_tbl%0d", i), 32'(q_f), 32'(ftab[i]));
        end
        chk("fib_wrap", 32'(wr_f), 32'h1);
        chk("fib_period", 32'(per_f), 32'd15);

        apply(0, 1'b1, 1'b0, '0, 1'b1);
        apply(0, 1'b1, 1'b0, '0, 1'b1);
        apply(0, 1'b0, 1'b1, 16'h0, 1'b1);
        chk("lock_q", 32'(q_g), 32'h1);
        chk("lock_pulse", 32'(lk_g), 32'h1);
        apply(0, 1'b0, 1'b1, 16'h0, 1'b1);
        chk("lock_b2b", 32'(lk_g), 32'h1);
        apply(0, 1'b1, 1'b1, 16'hA, 1'b1);
        chk("load_en_q", 32'(q_g), 32'hA);
        chk("load_en_wrap", 32'(wr_g), 32'h0);
        chk("load_en_lock", 32'(lk_g), 32'h0);
        chk("load_per_hold", 32'(per_g), 32'd15);
        for (int i = 0; i < 16; i++) apply(0, 1'b1, 1'b0, '0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            apply(2, 1'b1, 1'b0, '0, 1'b1);
            if (i < 3) chk($sformatf("st2_tbl%0d", i), 32'(q_s), 32'(stab[i]));
            if (i == 6) begin
                for (int k = 0; k < 3; k++) apply(2, 1'b0, 1'b0, '0, 1'b1);
                chk("st2_hold_q", 32'(q_s), 32'(mq[2]));
            end
        end
        chk("st2_wrap", 32'(wr_s), 32'h1);
        chk("st2_period", 32'(per_s), 32'd14);
        for (int k = 0; k < 3; k++) apply(2, 1'b0, 1'b0, '0, 1'b1);
        chk("st2_per_hold", 32'(per_s), 32'd14);
        chk("st2_q_hold", 32'(q_s), 32'h1);

        wcnt  = 0;
        wlast = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            apply(3, 1'b1, 1'b0, '0, 1'b0);
            if (wr_d) wcnt++;
            if (i == 65534) wlast = wr_d;
        end
        chk("w16_count", 32'(wcnt), 32'd1);
        chk("w16_last", 32'(wlast), 32'h1);
        chk("w16_period", 32'(per_d), 32'd65535);
        chk("w16_q", 32'(q_d), 32'h1);

        for (int i = 0; i < 40; i++) apply(3, 1'b1, 1'b0, '0, 1'b1);
        en_v[3] = 1'b1;
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_q16", 32'(q_d), 32'h1);
        chk("arst_per16", 32'(per_d), 32'h0);
        chk("arst_per4", 32'(per_g), 32'h0);
        chk("arst_qs", 32'(q_s), 32'h1);
        en_v = '0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        apply(3, 1'b1, 1'b0, '0, 1'b1);
        chk("post_rst_q16", 32'(q_d), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
